// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : muldiv_pkg
// Desc   : Shared types, op encodings and operand helpers for muldiv_unit.
// Rev    : 1.0
// ============================================================================
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic rs1_is_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
               (f == OP_DIV) || (f == OP_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
    endfunction

    // Magnitude of v; INT_MIN maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : muldiv_unit
// Desc   : Iterative RV32M multiply/divide unit, one bit per cycle, start/busy/done.
// Rev    : 1.0
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int              c_w2      = 2 * XLEN;
    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_last   = CNT_W'(XLEN - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [c_w2-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              w_accept;
    logic              w_sa, w_sb;
    logic              w_div0, w_ovf;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [c_w2-1:0]   w_mul_step, w_div_step;
    logic [c_w2-1:0]   w_prod;
    logic [XLEN-1:0]   w_quot, w_rem, w_final;

    assign w_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_sa     = rs1_is_signed(op);
    assign w_sb     = rs2_is_signed(op);
    assign w_abs_a  = abs_val(rs1_val, w_sa);
    assign w_abs_b  = abs_val(rs2_val, w_sb);
    assign w_div0   = op[2] && (rs2_val == '0);
    assign w_ovf    = ((op == OP_DIV) || (op == OP_REM)) &&
                      (rs1_val == c_int_min) && (rs2_val == {XLEN{1'b1}});

    // Multiply: multiplier sits in the low half and is shifted out as the product shifts in.
    assign w_sum      = {1'b0, acc_q[c_w2-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign w_mul_step = {w_sum, acc_q[XLEN-1:1]};

    // Divide: remainder in the high half, quotient bits shift into the low half.
    assign w_rem_sh   = acc_q[c_w2-1:XLEN-1];
    assign w_div_step = (w_rem_sh >= {1'b0, b_q})
                      ? {w_rem_sh[XLEN-1:0] - b_q, acc_q[XLEN-2:0], 1'b1}
                      : {w_rem_sh[XLEN-1:0],       acc_q[XLEN-2:0], 1'b0};

    assign w_prod  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign w_quot  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign w_rem   = neg_a_q ? -acc_q[c_w2-1:XLEN] : acc_q[c_w2-1:XLEN];
    assign w_final = op_q[2] ? (op_q[1] ? w_rem : w_quot)
                             : ((op_q[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[c_w2-1:XLEN]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    op_d  = op;
                    rd_d  = rd_in;
                    b_d   = w_abs_b;
                    cnt_d = '0;
                    // Special cases preload the accumulator so FIX's normal selection yields the answer.
                    if (w_div0) begin
                        neg_a_d = 1'b0;
                        neg_b_d = 1'b0;
                        acc_d   = {rs1_val, {XLEN{1'b1}}};
                        state_d = ST_FIX;
                    end else if (w_ovf) begin
                        neg_a_d = 1'b0;
                        neg_b_d = 1'b0;
                        acc_d   = {{XLEN{1'b0}}, c_int_min};
                        state_d = ST_FIX;
                    end else begin
                        neg_a_d = w_sa && rs1_val[XLEN-1];
                        neg_b_d = w_sb && rs2_val[XLEN-1];
                        acc_d   = {{XLEN{1'b0}}, w_abs_a};
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                acc_d = op_q[2] ? w_div_step : w_mul_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == c_last) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = w_final;
                    rd_out_d = rd_q;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_muldiv_unit
// Desc   : Self-checking bench for muldiv_unit against an arithmetic reference model.
// Rev    : 1.0
// ============================================================================
module tb_muldiv_unit;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit u_dut (
        .CLK     (CLK),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    always #5 CLK = ~CLK;

    // Reference: RV32M semantics via wide integer arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb;
        int          ia, ib;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return ia / ib;
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'b110: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return ia % ib;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && (b == 0)) return 2;
        if (f[2] && !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
        return 34;
    endfunction

    // Presents one request, returns at the falling edge of cycle 1 with start low.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r);
        @(negedge CLK);
        start   = 1'b1;
        op      = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = r;
        @(posedge CLK);
        @(negedge CLK);
        start   = 1'b0;
        op      = 3'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_in   = 5'($urandom);
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, output int cyc, output logic [31:0] res,
                          output logic [4:0] rdo);
        launch(f, a, b, r);
        wait_done(1, cyc);
        res = result;
        rdo = rd_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0;
        rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (3) @(negedge CLK);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        n_tests++; if (rd_out !== 5'h0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", rd_out); end
        rst_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_mul_timing();
        int bad_cyc;
        bad_cyc = 0;
        launch(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        for (int c = 1; c <= 33; c++) begin
            if ((busy !== 1'b1 || done !== 1'b0) && bad_cyc == 0) bad_cyc = c;
            @(negedge CLK);
        end
        n_tests++; if (bad_cyc != 0) begin n_fail++; $display("FAIL mul_busy_window: busy=%b done=%b wrong at cycle %0d, want busy=1 done=0", busy, done, bad_cyc); end
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mul_done_c34: got done=%b busy=%b want 1/0", done, busy); end
        n_tests++; if (result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h want ffffffeb", result); end
        n_tests++; if (rd_out !== 5'd5) begin n_fail++; $display("FAIL mul_rd: got %0d want 5", rd_out); end
        @(negedge CLK);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse: got %b want 0 in cycle 35", done); end
    endtask

    task automatic test_directed();
        logic [2:0]  fs [10] = '{3'b011, 3'b001, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                                 3'b100, 3'b111, 3'b100};
        logic [31:0] as [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000};
        logic [31:0] bs [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                                 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ex [10] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                 32'h8000_0000};
        int          lt [10] = '{34, 34, 34, 34, 34, 34, 34, 2, 2, 2};
        int          cyc;
        logic [31:0] res;
        logic [4:0]  rdo;
        for (int i = 0; i < 10; i++) begin
            run_op(fs[i], as[i], bs[i], 5'(i + 8), cyc, res, rdo);
            n_tests++; if (res !== ex[i]) begin n_fail++; $display("FAIL directed_%0d_result: op=%b got %h want %h", i, fs[i], res, ex[i]); end
            n_tests++; if (cyc != lt[i]) begin n_fail++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, cyc, lt[i]); end
        end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd30, cyc, res, rdo);
        n_tests++; if (res !== 32'h0 || cyc != 2 || rdo !== 5'd30) begin n_fail++; $display("FAIL rem_overflow: got %h c%0d rd%0d want 0 c2 rd30", res, cyc, rdo); end
    endtask

    task automatic test_ignore_busy();
        int cyc;
        launch(3'b000, 32'd3, 32'd5, 5'd7);
        repeat (4) @(negedge CLK);
        start = 1'b1; op = 3'b100; rs1_val = 32'd100; rs2_val = 32'd3; rd_in = 5'd9;
        @(negedge CLK);
        start = 1'b0;
        wait_done(6, cyc);
        n_tests++; if (cyc != 34 || result !== 32'd15 || rd_out !== 5'd7) begin n_fail++; $display("FAIL ignore_busy: got c%0d %h rd%0d want c34 0000000f rd7", cyc, result, rd_out); end
        @(negedge CLK);
        n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy_noqueue: got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_flush();
        int          cyc, seen;
        logic [31:0] res;
        logic [4:0]  rdo;
        run_op(3'b000, 32'd6, 32'd7, 5'd3, cyc, res, rdo);
        n_tests++; if (res !== 32'd42) begin n_fail++; $display("FAIL flush_setup: got %h want 2a", res); end
        launch(3'b101, 32'd1000, 32'd3, 5'd11);
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL flush_calc_idle: got busy=%b done=%b want 0/0", busy, done); end
        n_tests++; if (result !== 32'd42 || rd_out !== 5'd3) begin n_fail++; $display("FAIL flush_calc_hold: got %h rd%0d want 2a rd3", result, rd_out); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) seen++;
            @(negedge CLK);
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL flush_no_done: got %0d done cycles want 0", seen); end
        launch(3'b100, 32'd5, 32'd0, 5'd12);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        n_tests++; if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd42 || rd_out !== 5'd3) begin n_fail++; $display("FAIL flush_fix: got done=%b busy=%b %h rd%0d want 0 0 2a rd3", done, busy, result, rd_out); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        @(negedge CLK);
        start = 1'b1; op = 3'b011; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF; rd_in = 5'd1;
        @(posedge CLK);
        wait_done(0, cyc);
        if (cyc == 0) begin @(negedge CLK); cyc = 1; wait_done(1, cyc); end
        n_tests++; if (cyc != 34 || result !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL b2b_first: got c%0d %h want c34 fffffffe", cyc, result); end
        op = 3'b110; rs1_val = 32'hFFFF_FFF9; rs2_val = 32'd2; rd_in = 5'd2;
        @(negedge CLK);
        start = 1'b0;
        n_tests++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_no_idle: got done=%b busy=%b want 0/1", done, busy); end
        wait_done(1, cyc);
        n_tests++; if (cyc != 34 || result !== 32'hFFFF_FFFF || rd_out !== 5'd2) begin n_fail++; $display("FAIL b2b_second: got c%0d %h rd%0d want c34 ffffffff rd2", cyc, result, rd_out); end
    endtask

    task automatic test_async_reset();
        int          cyc, seen;
        logic [31:0] res;
        logic [4:0]  rdo;
        launch(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd13);
        repeat (14) @(negedge CLK);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || rd_out !== 5'h0) begin n_fail++; $display("FAIL async_reset: got busy=%b done=%b %h rd%0d want all 0", busy, done, result, rd_out); end
        seen = 0;
        @(negedge CLK);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (done === 1'b1) seen++;
            @(negedge CLK);
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL async_reset_no_done: got %0d done cycles want 0", seen); end
        run_op(3'b000, 32'd3, 32'd4, 5'd6, cyc, res, rdo);
        n_tests++; if (res !== 32'd12 || cyc != 34 || rdo !== 5'd6) begin n_fail++; $display("FAIL post_reset_mul: got %h c%0d rd%0d want c c34 rd6", res, cyc, rdo); end
    endtask

    task automatic test_random();
        int          cyc, sel;
        logic [2:0]  f;
        logic [31:0] a, b, res;
        logic [4:0]  r, rdo;
        for (int i = 0; i < 40; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            r   = 5'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(0, 9); end
            if (sel == 3) a = 32'h8000_0000;
            run_op(f, a, b, r, cyc, res, rdo);
            n_tests++; if (res !== ref_result(f, a, b)) begin n_fail++; $display("FAIL rand_%0d_result: op=%b a=%h b=%h got %h want %h", i, f, a, b, res, ref_result(f, a, b)); end
            n_tests++; if (rdo !== r) begin n_fail++; $display("FAIL rand_%0d_rd: got %0d want %0d", i, rdo, r); end
            n_tests++; if (cyc != ref_latency(f, a, b)) begin n_fail++; $display("FAIL rand_%0d_latency: got %0d want %0d", i, cyc, ref_latency(f, a, b)); end
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_directed();
        test_ignore_busy();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_muldiv_unit
`default_nettype wire
